// File: rtl/return_addr_stack_if.sv
// Command/status bundle between the sequencer (master) and the return-address stack (slave).
interface return_addr_stack_if #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic              clr_err;
    logic [ADDR_W-1:0] top_addr;
    logic [CW-1:0]     count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, push_addr, clr_err,
        input  top_addr, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_addr, clr_err,
        output top_addr, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_addr_stack.sv
// Return-address stack: circular array addressed by a top pointer, registered top entry,
// occupancy count, full/empty status and sticky overflow/underflow flags.
module return_addr_stack #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 4,
    parameter int WRAP_MODE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    return_addr_stack_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];

    logic [PW-1:0]     ptr_q, ptr_d, ptr_inc, ptr_dec, wr_idx;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] top_q, top_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              ovf_evt, unf_evt, wr_en;
    logic              is_empty, is_full;

    // DEPTH is a power of two, so pointer arithmetic wraps for free and never leaves the array.
    assign ptr_inc  = ptr_q + PTR_ONE;
    assign ptr_dec  = ptr_q - PTR_ONE;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    // Decode push/pop into next pointer, count, top value, memory write and error events.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
        ptr_d   = ptr_q;
        count_d = count_q;
        top_d   = top_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;

        if (bus.push && bus.pop) begin
            if (is_empty) begin
                // Nothing to replace: acts as a plain push but still counts as a bad pop.
                ptr_d   = ptr_inc;
                wr_idx  = ptr_inc;
                count_d = CNT_ONE;
                unf_evt = 1'b1;
            end else begin
                // Tail call: overwrite the current top in place.
                wr_idx = ptr_q;
            end
            wr_en = 1'b1;
            top_d = bus.push_addr;
        end else if (bus.push) begin
            if (!is_full || WRAP_MODE != 0) begin
                // When full in wrap mode, ptr+1 is the oldest slot, so it is overwritten.
                ptr_d  = ptr_inc;
                wr_idx = ptr_inc;
                wr_en  = 1'b1;
                top_d  = bus.push_addr;
                if (!is_full) begin
                    count_d = count_q + CNT_ONE;
                end
            end
            ovf_evt = is_full;
        end else if (bus.pop) begin
            if (is_empty) begin
                unf_evt = 1'b1;
            end else begin
                ptr_d   = ptr_dec;
                count_d = count_q - CNT_ONE;
                top_d   = (count_q == CNT_ONE) ? '0 : mem[ptr_dec];
            end
        end

        // A fresh error event beats a simultaneous clear.
        ovf_d = (ovf_q && !bus.clr_err) || ovf_evt;
        unf_d = (unf_q && !bus.clr_err) || unf_evt;
    end

    // Control state register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage write port; writes are suppressed during reset so a lost push leaves no trace.
    always_ff @(posedge clk) begin
        // NOTE: the array itself is not reset; entries above count are never read, so their contents do not matter.
        if (!reset && wr_en) begin
            mem[wr_idx] <= bus.push_addr;
        end
    end

    assign bus.top_addr  = top_q;
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: one reject-mode and one wrap-mode instance share stimulus and are
// compared every cycle against list-based reference models, plus directed spot checks.
module tb_return_addr_stack;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: entries held oldest-first in a plain list, per instance (0 = reject, 1 = wrap).
    logic [ADDR_W-1:0] ms [2][DEPTH];
    int                mc [2];
    bit                mov [2];
    bit                mun [2];

    return_addr_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) if0 ();
    return_addr_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) if1 ();

    return_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WRAP_MODE(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    return_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WRAP_MODE(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one operation to the list model of instance m.
    task automatic model_step(input int m, input bit ps, input bit pp,
                              input logic [ADDR_W-1:0] a, input bit clr, input bit rst);
        bit ov = 0;
        bit un = 0;
        if (rst) begin
            mc[m]  = 0;
            mov[m] = 0;
            mun[m] = 0;
            return;
        end
        if (ps && pp) begin
            if (mc[m] == 0) begin
                ms[m][0] = a;
                mc[m]    = 1;
                un       = 1;
            end else begin
                ms[m][mc[m]-1] = a;
            end
        end else if (ps) begin
            if (mc[m] < DEPTH) begin
                ms[m][mc[m]] = a;
                mc[m]++;
            end else begin
                ov = 1;
                if (m == 1) begin
                    for (int i = 0; i < DEPTH - 1; i++) ms[m][i] = ms[m][i+1];
                    ms[m][DEPTH-1] = a;
                end
            end
        end else if (pp) begin
            if (mc[m] == 0) un = 1;
            else mc[m]--;
        end
        mov[m] = (mov[m] && !clr) || ov;
        mun[m] = (mun[m] && !clr) || un;
    endtask

    // Compare every output of both instances with the model.
    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic [ADDR_W-1:0] exp_top;
            exp_top = (mc[m] == 0) ? '0 : ms[m][mc[m]-1];
            check($sformatf("w%0d_top", m), 32'(m == 0 ? if0.top_addr : if1.top_addr), 32'(exp_top));
            check($sformatf("w%0d_count", m), 32'(m == 0 ? if0.count : if1.count), 32'(mc[m]));
            check($sformatf("w%0d_empty", m), 32'(m == 0 ? if0.empty : if1.empty), 32'(mc[m] == 0));
            check($sformatf("w%0d_full", m), 32'(m == 0 ? if0.full : if1.full), 32'(mc[m] == DEPTH));
            check($sformatf("w%0d_ovf", m), 32'(m == 0 ? if0.overflow : if1.overflow), 32'(mov[m]));
            check($sformatf("w%0d_unf", m), 32'(m == 0 ? if0.underflow : if1.underflow), 32'(mun[m]));
        end
    endtask

    // Drive one cycle of stimulus to both instances, then check after the edge.
    task automatic step(input bit ps, input bit pp, input logic [ADDR_W-1:0] a,
                        input bit clr, input bit rst);
        reset         = rst;
        if0.push      = ps;  if1.push      = ps;
        if0.pop       = pp;  if1.pop       = pp;
        if0.push_addr = a;   if1.push_addr = a;
        if0.clr_err   = clr; if1.clr_err   = clr;
        @(posedge clk);
        #1;
        model_step(0, ps, pp, a, clr, rst);
        model_step(1, ps, pp, a, clr, rst);
        check_all();
    endtask

    task automatic do_reset();
        step(0, 0, '0, 0, 1);
    endtask

    task automatic do_push(input logic [ADDR_W-1:0] a);
        step(1, 0, a, 0, 0);
    endtask

    task automatic do_pop();
        step(0, 1, '0, 0, 0);
    endtask

    initial begin
        logic [ADDR_W-1:0] pop_exp0 [DEPTH];
        logic [ADDR_W-1:0] pop_exp1 [DEPTH];

        reset = 1'b1;
        if0.push = 0; if0.pop = 0; if0.push_addr = '0; if0.clr_err = 0;
        if1.push = 0; if1.pop = 0; if1.push_addr = '0; if1.clr_err = 0;

        // Plan 1: basic push/pop ordering.
        do_reset();
        check("p1_reset_empty", 32'(if0.empty), 32'd1);
        do_push(8'h12); do_push(8'h34); do_push(8'h56);
        check("p1_top", 32'(if0.top_addr), 32'h56);
        check("p1_count", 32'(if0.count), 32'd3);
        do_pop(); check("p1_pop1", 32'(if0.top_addr), 32'h34);
        do_pop(); check("p1_pop2", 32'(if0.top_addr), 32'h12);
        do_pop(); check("p1_pop3", 32'(if0.top_addr), 32'h00);
        check("p1_empty", 32'(if0.empty), 32'd1);

        // Plan 2/3: full-stack policy, reject (instance 0) vs wrap (instance 1).
        do_reset();
        for (int i = 1; i <= DEPTH + 1; i++) do_push(ADDR_W'(i));
        check("p2_top_hold", 32'(if0.top_addr), 32'h04);
        check("p2_full", 32'(if0.full), 32'd1);
        check("p2_ovf", 32'(if0.overflow), 32'd1);
        check("p3_top_wrap", 32'(if1.top_addr), 32'h05);
        check("p3_count", 32'(if1.count), 32'd4);
        check("p3_ovf", 32'(if1.overflow), 32'd1);
        pop_exp0[0] = 8'h03; pop_exp0[1] = 8'h02; pop_exp0[2] = 8'h01; pop_exp0[3] = 8'h00;
        pop_exp1[0] = 8'h04; pop_exp1[1] = 8'h03; pop_exp1[2] = 8'h02; pop_exp1[3] = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            do_pop();
            check($sformatf("p2_pop%0d", i), 32'(if0.top_addr), 32'(pop_exp0[i]));
            check($sformatf("p3_pop%0d", i), 32'(if1.top_addr), 32'(pop_exp1[i]));
        end
        check("p3_empty", 32'(if1.empty), 32'd1);

        // Plan 4: tail call, and push+pop on an empty stack.
        do_reset();
        do_push(8'h20);
        step(1, 1, 8'h40, 0, 0);
        check("p4_tail_top", 32'(if0.top_addr), 32'h40);
        check("p4_tail_count", 32'(if0.count), 32'd1);
        do_pop();
        step(1, 1, 8'h77, 0, 0);
        check("p4_empty_pp_top", 32'(if0.top_addr), 32'h77);
        check("p4_empty_pp_unf", 32'(if0.underflow), 32'd1);

        // Plan 5: underflow and clear priority.
        do_reset();
        do_pop();
        check("p5_unf", 32'(if0.underflow), 32'd1);
        step(0, 0, '0, 1, 0);
        check("p5_clr", 32'(if0.underflow), 32'd0);
        step(0, 1, '0, 1, 0);
        check("p5_clr_vs_evt", 32'(if0.underflow), 32'd1);

        // Plan 6: reset beats a concurrent push.
        do_reset();
        do_pop();
        do_push(8'hAA); do_push(8'hBB);
        step(1, 0, 8'hCC, 0, 1);
        check("p6_count", 32'(if0.count), 32'd0);
        check("p6_top", 32'(if0.top_addr), 32'd0);
        check("p6_unf", 32'(if0.underflow), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r_op;
            bit ps, pp, clr, rst;
            r_op = int'($urandom_range(99, 0));
            ps   = (r_op < 45) || (r_op >= 85 && r_op < 95);
            pp   = (r_op >= 45 && r_op < 95);
            clr  = ($urandom_range(9, 0) == 0);
            rst  = ($urandom_range(99, 0) == 0);
            step(ps, pp, ADDR_W'($urandom), clr, rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
